// File: rtl/button_gesture.sv
// Turns debounced button strobes into short/long/double press events.
// Optional auto-repeat of long_press: define BUTTON_GESTURE_REPEAT_EN.
module button_gesture #(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int LONG_MS     = 500,
    parameter int DOUBLE_MS   = 250,
    parameter int REPEAT_MS   = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_db,
    input  logic button_rising,
    input  logic button_falling,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic long_held
);

    localparam int CYC_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int PW = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam int MAX_LD = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
    localparam int MAX_MS = (MAX_LD > REPEAT_MS) ? MAX_LD : REPEAT_MS;
    localparam int MW = $clog2(MAX_MS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CYC_PER_MS - 1);
    localparam logic [MW-1:0] LONG_C     = MW'(LONG_MS);
    localparam logic [MW-1:0] DOUBLE_C   = MW'(DOUBLE_MS);
    localparam logic [MW-1:0] MAX_C      = MW'(MAX_MS);
`ifdef BUTTON_GESTURE_REPEAT_EN
    localparam logic [MW-1:0] REP_LAST   = MW'(REPEAT_MS - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        LONG,
        WAIT_REL
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [MW-1:0] ms_cnt_q;
    logic          ms_tick;
    logic          rise, fall;
    logic          short_d, long_d, double_d, rep_d;

    assign ms_tick = (presc_q == PRESC_LAST);
    // Coincident strobes carry no usable edge information.
    assign rise = button_rising & ~button_falling;
    assign fall = button_falling & ~button_rising;

    // Next-state and event selection; timeouts outrank release, rising outranks timeout.
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        rep_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                if (ms_cnt_q >= LONG_C) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end else if (fall) begin
                    state_d = WAIT2;
                end
            end
            WAIT2: begin
                if (rise) begin
                    state_d  = WAIT_REL;
                    double_d = 1'b1;
                end else if (ms_cnt_q >= DOUBLE_C) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            LONG: begin
                if (fall || !button_db) begin
                    state_d = IDLE;
                end
`ifdef BUTTON_GESTURE_REPEAT_EN
                else if (ms_tick && ms_cnt_q == REP_LAST) begin
                    long_d = 1'b1;
                    rep_d  = 1'b1;
                end
`endif
            end
            WAIT_REL: begin
                if (fall || !button_db) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, millisecond timebase and registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            ms_cnt_q     <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            long_held    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || rep_d) begin
                presc_q  <= '0;
                ms_cnt_q <= '0;
            end else begin
                presc_q <= ms_tick ? '0 : presc_q + PW'(1);
                if (ms_tick && ms_cnt_q < MAX_C) begin
                    ms_cnt_q <= ms_cnt_q + MW'(1);
                end
            end
            short_press  <= short_d;
            long_press   <= long_d;
            double_press <= double_d;
            long_held    <= (state_d == LONG);
        end
    end

endmodule

// File: tb/tb_button_gesture.sv
// Randomised scoreboard bench for button_gesture.
// Honours BUTTON_GESTURE_REPEAT_EN in its reference model.
`timescale 1ns/1ps
module tb_button_gesture;

    localparam int CLK_HZ   = 4000;
    localparam int CYC      = CLK_HZ / 1000;
    localparam int L_MS     = 20;
    localparam int D_MS     = 10;
    localparam int R_MS     = 5;
    localparam int LONG_CYC = L_MS * CYC;
    localparam int DBL_CYC  = D_MS * CYC;
    localparam int REP_CYC  = R_MS * CYC;

    typedef enum int {EV_SHORT, EV_LONG, EV_DOUBLE, EV_HELD_ON, EV_HELD_OFF} ev_e;
    typedef struct {
        int  cyc;
        ev_e kind;
    } ev_t;
    typedef enum int {P_IDLE, P_HELD, P_GAP, P_LONG, P_DRAIN} ph_e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic button_db = 1'b0;
    logic button_rising = 1'b0;
    logic button_falling = 1'b0;
    logic short_press, long_press, double_press, long_held;

    int  edge_cnt = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  long_seen = 0;
    bit  prev_db = 1'b0;
    bit  glitch_en = 1'b0;
    ev_t sb[$];
    ph_e ph = P_IDLE;
    int  t0 = 0;
    logic held_prev = 1'b0;

    button_gesture #(
        .CLK_FREQ_HZ(CLK_HZ),
        .LONG_MS(L_MS),
        .DOUBLE_MS(D_MS),
        .REPEAT_MS(R_MS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .button_db(button_db),
        .button_rising(button_rising),
        .button_falling(button_falling),
        .short_press(short_press),
        .long_press(long_press),
        .double_press(double_press),
        .long_held(long_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic push(int e, ev_e k);
        ev_t x;
        x.cyc = e;
        x.kind = k;
        sb.push_back(x);
    endtask

    // Reference: gesture rules expressed as deadlines measured from phase entry.
    task automatic model_step(int e, bit db, bit r, bit f);
        bit re;
        bit fe;
        re = r && !f;
        fe = f && !r;
        case (ph)
            P_IDLE: begin
                if (re) begin ph = P_HELD; t0 = e; end
            end
            P_HELD: begin
                if (e >= t0 + LONG_CYC + 1) begin
                    push(e, EV_LONG);
                    push(e, EV_HELD_ON);
                    ph = P_LONG;
                    t0 = e;
                end else if (fe) begin
                    ph = P_GAP;
                    t0 = e;
                end
            end
            P_GAP: begin
                if (re) begin
                    push(e, EV_DOUBLE);
                    ph = P_DRAIN;
                end else if (e >= t0 + DBL_CYC + 1) begin
                    push(e, EV_SHORT);
                    ph = P_IDLE;
                end
            end
            P_LONG: begin
                if (fe || !db) begin
                    push(e, EV_HELD_OFF);
                    ph = P_IDLE;
                end
`ifdef BUTTON_GESTURE_REPEAT_EN
                else if ((e - t0) % REP_CYC == 0) begin
                    push(e, EV_LONG);
                end
`endif
            end
            P_DRAIN: begin
                if (fe || !db) ph = P_IDLE;
            end
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic see(ev_e k);
        ev_t x;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL event: got %s at edge %0d, required no event",
                     k.name(), edge_cnt);
        end else begin
            x = sb.pop_front();
            if (x.kind != k || x.cyc != edge_cnt) begin
                n_fail++;
                $display("FAIL event: got %s at edge %0d, required %s at edge %0d",
                         k.name(), edge_cnt, x.kind.name(), x.cyc);
            end
        end
    endtask

    // Monitor: every pulse and every long_held transition consumes one expectation.
    always @(negedge clk) begin
        if (short_press) see(EV_SHORT);
        if (long_press) begin
            see(EV_LONG);
            long_seen++;
        end
        if (double_press) see(EV_DOUBLE);
        if (long_held != held_prev) see(long_held ? EV_HELD_ON : EV_HELD_OFF);
        held_prev = long_held;
    end

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(bit db, bit r, bit f);
        button_db = db;
        button_rising = r;
        button_falling = f;
        model_step(edge_cnt + 1, db, r, f);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(bit lvl, int n);
        bit r;
        bit f;
        for (int i = 0; i < n; i++) begin
            r = lvl && !prev_db;
            f = !lvl && prev_db;
            if (glitch_en && !r && !f && $urandom_range(0, 199) == 0) begin
                r = 1'b1;
                f = 1'b1;
            end
            step(lvl, r, f);
            prev_db = lvl;
        end
    endtask

    task automatic do_reset(int n, bit lvl);
        rst_n = 1'b0;
        button_db = lvl;
        button_rising = 1'b0;
        button_falling = 1'b0;
        if (ph == P_LONG) push(edge_cnt, EV_HELD_OFF);
        ph = P_IDLE;
        #1;
        chk("rst short_press", int'(short_press), 0);
        chk("rst long_press", int'(long_press), 0);
        chk("rst double_press", int'(double_press), 0);
        chk("rst long_held", int'(long_held), 0);
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_db = lvl;
    endtask

    int lp0;
    int plen;
    int glen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("init short_press", int'(short_press), 0);
        chk("init long_press", int'(long_press), 0);
        chk("init double_press", int'(double_press), 0);
        chk("init long_held", int'(long_held), 0);
        rst_n = 1'b1;
        hold(0, 5);

        // short press
        hold(1, 5 * CYC);
        hold(0, 20 * CYC);
        // long press with release
        hold(1, 30 * CYC);
        hold(0, 20 * CYC);
        // double press
        hold(1, 5 * CYC);
        hold(0, 5 * CYC);
        hold(1, 5 * CYC);
        hold(0, 20 * CYC);
        // rising exactly in the timeout cycle
        hold(1, 5 * CYC);
        hold(0, DBL_CYC + 1);
        hold(1, 5 * CYC);
        hold(0, 20 * CYC);
        // rising in the first cycle back in idle
        hold(1, 5 * CYC);
        hold(0, DBL_CYC + 2);
        hold(1, 5 * CYC);
        hold(0, 20 * CYC);
        // release within a cycle of the long deadline
        hold(1, LONG_CYC);
        hold(0, 20 * CYC);
        hold(1, LONG_CYC + 1);
        hold(0, 20 * CYC);
        // coincident strobes in idle are ignored
        step(0, 1, 1);
        hold(0, 20 * CYC);

        // long hold: count of long_press pulses
        lp0 = long_seen;
        hold(1, 50 * CYC);
        hold(0, 10 * CYC);
`ifdef BUTTON_GESTURE_REPEAT_EN
        chk("long pulses per hold", long_seen - lp0, 6);
`else
        chk("long pulses per hold", long_seen - lp0, 1);
`endif

        // reset mid PRESS1, released during reset
        hold(1, 12 * CYC);
        do_reset(3, 0);
        hold(0, 30 * CYC);
        // reset mid LONG
        hold(1, LONG_CYC + 5);
        do_reset(3, 0);
        hold(0, 30 * CYC);
        // button held through reset: no gesture
        hold(1, 3 * CYC);
        do_reset(3, 1);
        hold(1, 30 * CYC);
        hold(0, 30 * CYC);

        // randomised gestures around the timing boundaries
        glitch_en = 1'b1;
        for (int g = 0; g < 100; g++) begin
            case ($urandom_range(0, 3))
                0: plen = $urandom_range(1, 60);
                1: plen = $urandom_range(LONG_CYC - 2, LONG_CYC + 3);
                2: plen = $urandom_range(90, 200);
                default: plen = $urandom_range(1, 20);
            endcase
            case ($urandom_range(0, 2))
                0: glen = $urandom_range(1, 30);
                1: glen = $urandom_range(DBL_CYC - 2, DBL_CYC + 4);
                default: glen = $urandom_range(45, 80);
            endcase
            hold(1, plen);
            hold(0, glen);
        end
        glitch_en = 1'b0;
        hold(0, 30 * CYC);

        chk("expected events left over", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
